// File: rtl/hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_unit_pkg
// Shared types for the hazard controller and its neighbours (forwarding, the
// source-use decoder): register index, opcode, hazard FSM state and the
// RV64 major opcodes needed to decide which source registers are read.
// ---------------------------------------------------------------------------
package hazard_unit_pkg;

    typedef logic [4:0] reg_t;
    typedef logic [6:0] opcode_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } hu_state_t;

    localparam opcode_t OPC_LOAD   = 7'b0000011;
    localparam opcode_t OPC_OP_IMM = 7'b0010011;
    localparam opcode_t OPC_AUIPC  = 7'b0010111;
    localparam opcode_t OPC_STORE  = 7'b0100011;
    localparam opcode_t OPC_OP     = 7'b0110011;
    localparam opcode_t OPC_LUI    = 7'b0110111;
    localparam opcode_t OPC_OP_32  = 7'b0111011;
    localparam opcode_t OPC_BRANCH = 7'b1100011;
    localparam opcode_t OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/hazard_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_unit_if
// Bundle of every hazard_unit signal.
//   modport hu : the controller's view (pipeline status in, controls out)
//   modport tb : the driver's view (pipeline status out, controls in)
// ---------------------------------------------------------------------------
interface hazard_unit_if #(
    parameter int CNT_W = 32
);
    import hazard_unit_pkg::*;

    logic             clk;
    logic             rst;
    reg_t             rs1_fd;
    reg_t             rs2_fd;
    opcode_t          opcode_fd;
    reg_t             rd_de;
    logic             MemRead_de;
    logic             md_op_de;
    logic             md_done;
    logic             mem_req_em;
    logic             dmem_ready;
    logic             branch_taken_em;
    logic             stall_fd;
    logic             stall_de;
    logic             stall_em;
    logic             flush_fd;
    logic             flush_de;
    logic             flush_mw;
    logic             md_start;
    logic             md_error;
    logic [CNT_W-1:0] stall_count;

    modport hu (
        input  clk, rst, rs1_fd, rs2_fd, opcode_fd, rd_de, MemRead_de, md_op_de,
               md_done, mem_req_em, dmem_ready, branch_taken_em,
        output stall_fd, stall_de, stall_em, flush_fd, flush_de, flush_mw,
               md_start, md_error, stall_count
    );

    modport tb (
        output clk, rst, rs1_fd, rs2_fd, opcode_fd, rd_de, MemRead_de, md_op_de,
               md_done, mem_req_em, dmem_ready, branch_taken_em,
        input  stall_fd, stall_de, stall_em, flush_fd, flush_de, flush_mw,
               md_start, md_error, stall_count
    );

endinterface

// File: rtl/hazard_unit_src_use_decode.sv
// ---------------------------------------------------------------------------
// src_use_decode
// Combinational decode of which source registers an instruction really reads,
// so a matching but unused rs field never raises a false hazard.
//   opcode   : major opcode of the instruction
//   uses_rs1 : rs1 is read (everything except LUI, AUIPC, JAL)
//   uses_rs2 : rs2 is read (R-type, RV64 R-type word ops, stores, branches)
// ---------------------------------------------------------------------------
module src_use_decode
    import hazard_unit_pkg::*;
(
    input  opcode_t opcode,
    output logic    uses_rs1,
    output logic    uses_rs2
);

    always_comb begin
        uses_rs1 = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
        uses_rs2 = opcode inside {OPC_OP, OPC_OP_32, OPC_STORE, OPC_BRANCH};
    end

endmodule

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Hazard controller for the 5-stage RV64 pipeline: load-use, multi-cycle
// mul/div, data-memory wait states and taken-branch redirects.
// Priority in every state: mem wait > mul/div > branch flush > load-use.
//   inputs : FD sources/opcode, DE rd/load/muldiv flags, md_done pulse,
//            EM memory request + dmem_ready, EM taken branch
//   outputs: stall_fd/de/em (hold), flush_fd/de/mw (bubble) -- combinational;
//            md_start pulse, sticky md_error, saturating stall_count -- registered
// ---------------------------------------------------------------------------
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MD_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  reg_t             rs1_fd,
    input  reg_t             rs2_fd,
    input  opcode_t          opcode_fd,
    input  reg_t             rd_de,
    input  logic             MemRead_de,
    input  logic             md_op_de,
    input  logic             md_done,
    input  logic             mem_req_em,
    input  logic             dmem_ready,
    input  logic             branch_taken_em,
    output logic             stall_fd,
    output logic             stall_de,
    output logic             stall_em,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             flush_mw,
    output logic             md_start,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_count
);

    localparam int              TO_W    = $clog2(MD_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    hu_state_t       state, state_nxt;
    hu_state_t       ret_state, ret_nxt;  // where MEM_WAIT goes back to
    hu_state_t       eff_state;           // the state the non-memory rules see
    logic            md_finished, md_fin_nxt;
    logic [TO_W-1:0] md_cnt;
    logic            md_start_nxt;
    logic            uses_rs1, uses_rs2;
    logic            mem_stall, load_use, timeout_hit;

    src_use_decode u_src_use_decode (
        .opcode   (opcode_fd),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    assign mem_stall   = mem_req_em && !dmem_ready;
    assign load_use    = MemRead_de && (rd_de != '0) &&
                         ((uses_rs1 && (rs1_fd == rd_de)) ||
                          (uses_rs2 && (rs2_fd == rd_de)));
    assign timeout_hit = (state == MD_BUSY) && (md_cnt == TO_LAST);
    // A memory wait only suspends the mul/div sequence; the other rules keep
    // seeing the interrupted state.
    assign eff_state   = (state == MEM_WAIT) ? ret_state : state;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        stall_fd     = 1'b0;
        stall_de     = 1'b0;
        stall_em     = 1'b0;
        flush_fd     = 1'b0;
        flush_de     = 1'b0;
        flush_mw     = 1'b0;
        md_start_nxt = 1'b0;
        state_nxt    = RUN;
        ret_nxt      = RUN;
        md_fin_nxt   = 1'b0;

        // Controls are forced low while reset is held, whatever the inputs.
        if (!rst) begin
            if (mem_stall) begin
                stall_fd  = 1'b1;
                stall_de  = 1'b1;
                stall_em  = 1'b1;
                flush_mw  = 1'b1;
                state_nxt = MEM_WAIT;
                ret_nxt   = eff_state;
                md_fin_nxt = md_finished;
                // A mul/div that finishes while DE is frozen must not relaunch
                // on release, since the same instruction is still in DE.
                if ((eff_state == MD_BUSY) && (md_done || timeout_hit)) begin
                    ret_nxt    = RUN;
                    md_fin_nxt = 1'b1;
                end
            end else if ((eff_state == MD_BUSY) && !md_done && !timeout_hit) begin
                stall_fd  = 1'b1;
                stall_de  = 1'b1;
                state_nxt = MD_BUSY;
            end else if ((eff_state == RUN) && md_op_de && !md_finished) begin
                md_start_nxt = 1'b1;
                stall_fd     = 1'b1;
                stall_de     = 1'b1;
                state_nxt    = MD_BUSY;
            end else if (branch_taken_em) begin
                flush_fd = 1'b1;
                flush_de = 1'b1;
            end else if ((eff_state == RUN) && load_use) begin
                stall_fd = 1'b1;
                flush_de = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            ret_state   <= RUN;
            md_finished <= 1'b0;
            md_cnt      <= '0;
            md_start    <= 1'b0;
            md_error    <= 1'b0;
            stall_count <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values of the others.
            state       <= state_nxt;
            ret_state   <= ret_nxt;
            md_finished <= md_fin_nxt;
            md_start    <= md_start_nxt;
            md_error    <= md_error || timeout_hit;
            // Busy cycles accumulate across an interrupting memory wait.
            if (state == MD_BUSY) begin
                md_cnt <= md_cnt + 1'b1;
            end else if (state == RUN) begin
                md_cnt <= '0;
            end
            if (stall_fd && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
// Self-checking bench for hazard_unit. Each cycle the stimulus is driven on
// the falling edge, the expected controls are queued, and the queued entry is
// compared against the DUT shortly before the next rising edge.
// stall_count is narrowed to 4 bits so that saturation is reached.
// ---------------------------------------------------------------------------
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    localparam int CNT_W      = 4;
    localparam int MD_TIMEOUT = 8;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    hazard_unit_if #(.CNT_W(CNT_W)) hif ();

    hazard_unit #(
        .CNT_W      (CNT_W),
        .MD_TIMEOUT (MD_TIMEOUT)
    ) dut (
        .clk             (hif.clk),
        .rst             (hif.rst),
        .rs1_fd          (hif.rs1_fd),
        .rs2_fd          (hif.rs2_fd),
        .opcode_fd       (hif.opcode_fd),
        .rd_de           (hif.rd_de),
        .MemRead_de      (hif.MemRead_de),
        .md_op_de        (hif.md_op_de),
        .md_done         (hif.md_done),
        .mem_req_em      (hif.mem_req_em),
        .dmem_ready      (hif.dmem_ready),
        .branch_taken_em (hif.branch_taken_em),
        .stall_fd        (hif.stall_fd),
        .stall_de        (hif.stall_de),
        .stall_em        (hif.stall_em),
        .flush_fd        (hif.flush_fd),
        .flush_de        (hif.flush_de),
        .flush_mw        (hif.flush_mw),
        .md_start        (hif.md_start),
        .md_error        (hif.md_error),
        .stall_count     (hif.stall_count)
    );

    initial hif.clk = 1'b0;
    always #5 hif.clk = ~hif.clk;

    // ctl bit order: stall_fd stall_de stall_em flush_fd flush_de flush_mw md_start md_error
    typedef struct {
        string            tag;
        logic [7:0]       ctl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt  = 0;
    logic exp_err  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] ctl_now();
        return {hif.stall_fd, hif.stall_de, hif.stall_em, hif.flush_fd,
                hif.flush_de, hif.flush_mw, hif.md_start, hif.md_error};
    endfunction

    task automatic drive(input logic mr, input reg_t rd, input reg_t r1, input reg_t r2,
                         input opcode_t op, input logic mdop, input logic mdd,
                         input logic mreq, input logic rdy, input logic br);
        hif.MemRead_de      = mr;
        hif.rd_de           = rd;
        hif.rs1_fd          = r1;
        hif.rs2_fd          = r2;
        hif.opcode_fd       = op;
        hif.md_op_de        = mdop;
        hif.md_done         = mdd;
        hif.mem_req_em      = mreq;
        hif.dmem_ready      = rdy;
        hif.branch_taken_em = br;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, OPC_OP_IMM, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Called just after the falling edge with inputs already driven.
    task automatic step(input string tag, input logic [7:0] ctl);
        exp_t e;
        e.tag = tag;
        e.ctl = ctl | {7'b0, exp_err};
        e.cnt = CNT_W'(exp_cnt);
        sb.push_back(e);
        if (ctl[7] && (exp_cnt < CNT_MAX)) exp_cnt++;
        #2;
        e = sb.pop_front();
        check({e.tag, ".ctl"}, 32'(ctl_now()), 32'(e.ctl));
        check({e.tag, ".cnt"}, 32'(hif.stall_count), 32'(e.cnt));
        @(negedge hif.clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        hif.rst = 1'b1;
        idle();
        #1;
        check("reset.ctl", 32'(ctl_now()), 32'h0);
        check("reset.cnt", 32'(hif.stall_count), 32'h0);
        repeat (2) @(negedge hif.clk);
        hif.rst = 1'b0;

        idle();                                                  step("idle", 8'b0000_0000);

        // Load-use and source-use decode
        drive(1, 5'd5, 5'd5, 5'd0, OPC_OP,     0, 0, 0, 1, 0);  step("lu_rs1", 8'b1000_1000);
        idle();                                                  step("lu_after", 8'b0000_0000);
        drive(1, 5'd0, 5'd0, 5'd0, OPC_OP,     0, 0, 0, 1, 0);  step("lu_rd0", 8'b0000_0000);
        drive(1, 5'd7, 5'd7, 5'd0, OPC_LUI,    0, 0, 0, 1, 0);  step("lu_lui", 8'b0000_0000);
        drive(1, 5'd7, 5'd0, 5'd7, OPC_OP_IMM, 0, 0, 0, 1, 0);  step("lu_imm_rs2", 8'b0000_0000);
        drive(1, 5'd7, 5'd0, 5'd7, OPC_STORE,  0, 0, 0, 1, 0);  step("lu_st_rs2", 8'b1000_1000);

        // Mul/div: done on cycle 6
        drive(0, 5'd0, 5'd0, 5'd0, OPC_OP_IMM, 1, 0, 0, 1, 0);  step("md_c1", 8'b1100_0000);
        step("md_c2", 8'b1100_0010);
        for (int i = 3; i <= 5; i++) step($sformatf("md_c%0d", i), 8'b1100_0000);
        hif.md_done = 1'b1;                                      step("md_c6", 8'b0000_0000);
        idle();                                                  step("md_c7", 8'b0000_0000);

        // Memory wait of 3 cycles, release on the 4th
        drive(0, 5'd0, 5'd0, 5'd0, OPC_OP_IMM, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 3; i++) step($sformatf("mw_c%0d", i), 8'b1110_0100);
        hif.dmem_ready = 1'b1;                                   step("mw_rel", 8'b0000_0000);
        idle();                                                  step("mw_idle", 8'b0000_0000);

        // Taken branch deferred by a memory wait
        drive(0, 5'd0, 5'd0, 5'd0, OPC_OP_IMM, 0, 0, 1, 0, 1);
        for (int i = 1; i <= 2; i++) step($sformatf("brm_c%0d", i), 8'b1110_0100);
        hif.dmem_ready = 1'b1;                                   step("brm_rel", 8'b0001_1000);
        idle();                                                  step("brm_idle", 8'b0000_0000);

        // Branch overrides a simultaneous load-use
        drive(1, 5'd5, 5'd5, 5'd0, OPC_OP,     0, 0, 0, 1, 1);  step("br_lu", 8'b0001_1000);
        idle();                                                  step("br_idle", 8'b0000_0000);

        // Memory wait interrupting MD_BUSY returns to MD_BUSY
        drive(0, 5'd0, 5'd0, 5'd0, OPC_OP_IMM, 1, 0, 0, 1, 0);  step("mdm_entry", 8'b1100_0000);
        drive(0, 5'd0, 5'd0, 5'd0, OPC_OP_IMM, 1, 0, 1, 0, 0);  step("mdm_wait", 8'b1110_0110);
        hif.dmem_ready = 1'b1;                                   step("mdm_rel", 8'b1100_0000);
        drive(0, 5'd0, 5'd0, 5'd0, OPC_OP_IMM, 1, 1, 0, 1, 0);  step("mdm_done", 8'b0000_0000);
        idle();                                                  step("mdm_idle", 8'b0000_0000);

        // Mul/div timeout after 8 busy cycles
        drive(0, 5'd0, 5'd0, 5'd0, OPC_OP_IMM, 1, 0, 0, 1, 0);  step("to_entry", 8'b1100_0000);
        step("to_b1", 8'b1100_0010);
        for (int i = 2; i <= 7; i++) step($sformatf("to_b%0d", i), 8'b1100_0000);
        step("to_b8", 8'b0000_0000);
        exp_err = 1'b1;
        idle();                                                  step("to_run", 8'b0000_0000);
        drive(1, 5'd5, 5'd5, 5'd0, OPC_OP,     0, 0, 0, 1, 0);  step("to_lu", 8'b1000_1000);
        idle();                                                  step("to_idle", 8'b0000_0000);

        // Asynchronous reset in the middle of MD_BUSY
        drive(0, 5'd0, 5'd0, 5'd0, OPC_OP_IMM, 1, 0, 0, 1, 0);  step("rst_entry", 8'b1100_0000);
        step("rst_b1", 8'b1100_0010);
        #2;
        hif.rst = 1'b1;
        #1;
        check("rst_async.ctl", 32'(ctl_now()), 32'h0);
        check("rst_async.cnt", 32'(hif.stall_count), 32'h0);
        @(negedge hif.clk);
        idle();
        @(negedge hif.clk);
        hif.rst = 1'b0;
        exp_err = 1'b0;
        exp_cnt = 0;
        step("post_rst", 8'b0000_0000);
        drive(1, 5'd9, 5'd0, 5'd9, OPC_BRANCH, 0, 0, 0, 1, 0);  step("post_lu", 8'b1000_1000);
        idle();                                                  step("post_idle", 8'b0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
